// File: rtl/led_pattern_engine.sv
// led_pattern_engine: N-channel LED driver with a programmable tick rate,
// PWM brightness, per-channel invert and three patterns (binary count,
// blink-all, breathe). The LED drive and the tick pulse are registered.
module led_pattern_engine #(
  parameter int NUM_LEDS    = 8,
  parameter int TICK_CYCLES = 50000000,
  parameter int PWM_WIDTH   = 4
) (
  input  logic                 clk_a,
  input  logic                 rst_a_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [PWM_WIDTH-1:0] brightness,
  input  logic [NUM_LEDS-1:0]  invert,
  output logic                 tick,
  output logic [NUM_LEDS-1:0]  led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } breathe_state_t;

  localparam int                   PRE_W   = $clog2(TICK_CYCLES);
  localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] LVL_ONE = PWM_WIDTH'(1);

  logic [PRE_W-1:0]     prescaler;
  logic [NUM_LEDS-1:0]  step;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] level;
  logic [PWM_WIDTH-1:0] level_d;
  logic [1:0]           mode_q;
  breathe_state_t       state, state_d;

  logic                 running;
  logic                 clear;
  logic                 tick_event;
  logic [PWM_WIDTH-1:0] duty;
  logic                 pwm_on;
  logic [NUM_LEDS-1:0]  pattern;
  logic [NUM_LEDS-1:0]  led_d;
  logic [PWM_WIDTH:0]   level_inc;

  // A mode change or a dropped enable restarts the pattern from scratch;
  // the tick that would have fired in that cycle is swallowed.
  assign running    = enable && (mode != MODE_OFF);
  assign clear      = !enable || (mode != mode_q);
  assign tick_event = !clear && running && (prescaler == PRE_MAX);

  // Prescaler, pattern step, mode history and the registered tick pulse.
  // NOTE: every flop resets asynchronously and all state updates use <=, so
  // reads in the same edge see the pre-edge values regardless of block order.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      prescaler <= '0;
      step      <= '0;
      mode_q    <= '0;
      tick      <= 1'b0;
    end else begin
      mode_q <= mode;
      tick   <= tick_event;
      if (clear) begin
        prescaler <= '0;
        step      <= '0;
      end else if (running) begin
        prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + PRE_W'(1);
        if (tick_event) step <= step + NUM_LEDS'(1);
      end
    end
  end

  // Free-running PWM phase counter; wraps naturally at its width.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
  end

  // Breathe state register.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state <= RAMP_UP;
      level <= '0;
    end else begin
      state <= state_d;
      level <= level_d;
    end
  end

  // Breathe next-state: clear, then zero ceiling, then clamp, then the ramp.
  // NOTE: defaults are assigned first so no path through this block leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    level_d   = level;
    level_inc = {1'b0, level} + {{PWM_WIDTH{1'b0}}, 1'b1};
    if (clear) begin
      state_d = RAMP_UP;
      level_d = '0;
    end else if (brightness == '0) begin
      state_d = RAMP_UP;
      level_d = '0;
    end else if (level > brightness) begin
      state_d = RAMP_DOWN;
      level_d = brightness;
    end else if (tick_event && (mode == MODE_BREATHE)) begin
      case (state)
        RAMP_UP: begin
          if (level_inc >= {1'b0, brightness}) begin
            level_d = brightness;
            state_d = RAMP_DOWN;
          end else begin
            level_d = level + LVL_ONE;
          end
        end
        RAMP_DOWN: begin
          if (level <= LVL_ONE) begin
            level_d = '0;
            state_d = RAMP_UP;
          end else begin
            level_d = level - LVL_ONE;
          end
        end
        default: begin
          level_d = '0;
          state_d = RAMP_UP;
        end
      endcase
    end
  end

  // Duty selection, PWM comparison and the per-mode pattern.
  always_comb begin
    duty    = (mode == MODE_BREATHE) ? level : brightness;
    pwm_on  = (duty == '1) || (pwm_cnt < duty);
    pattern = '0;
    case (mode)
      MODE_COUNT:   pattern = step;
      MODE_BLINK:   pattern = {NUM_LEDS{step[0]}};
      MODE_BREATHE: pattern = '1;
      default:      pattern = '0;
    endcase
    led_d = (running && pwm_on) ? (pattern ^ invert) : '0;
  end

  // Registered LED drive; invert only acts during the PWM on phase.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) led <= '0;
    else          led <= led_d;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed scenarios followed by random stimulus, with
// every cycle compared against an arithmetic reference model of the LED driver.
module tb_led_pattern_engine;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int P  = 2;

  logic         clk_a = 1'b0;
  logic         rst_a_n = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [P-1:0] brightness = '0;
  logic [N-1:0] invert = '0;
  logic         tick;
  logic [N-1:0] led;

  led_pattern_engine #(.NUM_LEDS(N), .TICK_CYCLES(TC), .PWM_WIDTH(P)) dut (
    .clk_a      (clk_a),
    .rst_a_n    (rst_a_n),
    .enable     (enable),
    .mode       (mode),
    .brightness (brightness),
    .invert     (invert),
    .tick       (tick),
    .led        (led)
  );

  always #5 clk_a = ~clk_a;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: time since reset, running cycles since the last restart,
  // ticks since the last restart, and the breathe level with its direction.
  int m_cyc, m_runs, m_ticks, m_level, m_mode_q, exp_led;
  bit m_down, exp_tick;

  task automatic model_reset();
    m_cyc = 0; m_runs = 0; m_ticks = 0; m_level = 0; m_down = 0;
    m_mode_q = 0; exp_led = 0; exp_tick = 0;
  endtask

  task automatic model_edge();
    int md, b, duty, pat, full;
    bit restart, run_on, tev, on;
    md      = int'(mode);
    b       = int'(brightness);
    full    = (1 << N) - 1;
    restart = !enable || (md != m_mode_q);
    run_on  = enable && (md != 0);
    tev     = !restart && run_on && ((m_runs % TC) == TC - 1);
    duty    = (md == 3) ? m_level : b;
    on      = (duty == (1 << P) - 1) || ((m_cyc % (1 << P)) < duty);
    case (md)
      1:       pat = m_ticks % (1 << N);
      2:       pat = (m_ticks % 2 == 1) ? full : 0;
      3:       pat = full;
      default: pat = 0;
    endcase
    exp_led  = (run_on && on) ? (pat ^ int'(invert)) : 0;
    exp_tick = tev;
    if (restart) begin
      m_runs = 0; m_ticks = 0; m_level = 0; m_down = 0;
    end else begin
      if (run_on) m_runs++;
      if (tev) m_ticks++;
      if (b == 0) begin
        m_level = 0; m_down = 0;
      end else if (m_level > b) begin
        m_level = b; m_down = 1;
      end else if (tev && md == 3) begin
        if (!m_down) begin
          if (m_level + 1 >= b) begin m_level = b; m_down = 1; end
          else m_level++;
        end else begin
          if (m_level - 1 <= 0) begin m_level = 0; m_down = 0; end
          else m_level--;
        end
      end
    end
    m_mode_q = md;
    m_cyc++;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk_a);
    model_edge();
    #1;
    check({tag, "/tick"}, 32'(tick), 32'(exp_tick));
    check({tag, "/led"}, 32'(led), 32'(exp_led));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    int k;
    model_reset();
    enable = 1'b1; mode = 2'd1; brightness = 2'd3; invert = 4'hF;
    #22 rst_a_n = 1'b1;
    run("pre_reset", 3);

    // Asynchronous reset in the middle of a cycle, then first-tick latency.
    rst_a_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'd0);
    check("async_tick", 32'(tick), 32'd0);
    model_reset();
    invert = 4'h0;
    #2 rst_a_n = 1'b1;
    k = 0;
    do begin
      cyc("release");
      k++;
    end while (!tick && k < 20);
    check("first_tick_latency", 32'(k), 32'd5);

    // Binary count through a full wrap of the step counter.
    run("count", 70);

    // Blink-all PWM at quarter duty, then fully dark.
    mode = 2'd2; brightness = 2'd1;
    run("pwm_quarter", 40);
    brightness = 2'd0;
    run("pwm_zero", 20);

    // Invert mask with step held at zero after the mode change.
    mode = 2'd1; brightness = 2'd3; invert = 4'b1010;
    run("invert_on", 3);
    brightness = 2'd0;
    run("invert_dark", 3);
    invert = 4'h0;

    // Breathe ramp, then a ceiling drop while at the top.
    mode = 2'd3; brightness = 2'd2;
    run("breathe", 60);
    for (int i = 0; i < 50 && m_level != 2; i++) cyc("breathe_seek");
    brightness = 2'd1;
    run("breathe_clamp", 12);

    // Mode change with a non-zero step, then an enable drop.
    mode = 2'd1; brightness = 2'd3;
    for (int i = 0; i < 100 && m_ticks != 5; i++) cyc("seek_step5");
    mode = 2'd2;
    run("mode_change", 10);
    enable = 1'b0;
    run("enable_low", 3);
    enable = 1'b1;
    run("resume", 12);

    // Random stimulus with slowly changing controls.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(149) == 0) enable = ~enable;
      if ($urandom_range(29) == 0) brightness = P'($urandom_range(3));
      if ($urandom_range(49) == 0) invert = N'($urandom_range(15));
      cyc("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised, multi-mode LED driver for board bring-up designs.
- Generalises the fixed counter-to-LED blinker to N channels.
- Adds a programmable tick rate, PWM brightness, per-channel invert, and three pattern modes: binary count, blink-all, and breathe.
- Sits between a board clock/reset (the PS fabric clock or the external oscillator) and the LED pins; the switches drive the invert mask directly.

Parameters:
- NUM_LEDS, 8, number of LED channels (1..32).
- TICK_CYCLES, 50000000, clk_a cycles per pattern tick (>=2); default gives a 0.5 s tick at 100 MHz.
- PWM_WIDTH, 4, bit width of the PWM counter and of brightness (2..8).

Ports:
- clk_a  input  1  pattern/PWM clock.
- rst_a_n  input  1  reset, asynchronous, active-low.
- enable  input  1  high = run; low = LEDs dark, pattern state cleared.
- mode  input  2  0 = off, 1 = binary count, 2 = blink-all, 3 = breathe.
- brightness  input  PWM_WIDTH  duty setting; breathe ceiling in mode 3.
- invert  input  NUM_LEDS  per-channel XOR mask, applied only while the PWM phase is on.
- tick  output  1  single-cycle pulse at every pattern tick.
- led  output  NUM_LEDS  registered LED drive.

Behaviour:
- Reset (rst_a_n low, asynchronous):
  - prescaler = 0, step = 0, pwm_cnt = 0, level = 0, state = RAMP_UP, mode_q = 0.
  - tick = 0, led = 0.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick is registered; it is 1 for exactly the cycle after the prescaler holds TICK_CYCLES-1.
  - Counts only while enable = 1 and mode != 0.
- pwm_cnt:
  - PWM_WIDTH-bit free-running counter that wraps at 2^PWM_WIDTH-1 -> 0.
  - Runs regardless of enable.
- pwm_on = (duty == all-ones) or (pwm_cnt < duty).
  - duty = 0 -> never on; duty = max -> always on.
  - duty = brightness in modes 1 and 2; duty = level in mode 3.
- step:
  - NUM_LEDS-bit counter, incremented on each tick; wraps from all-ones to 0.
  - Mode 2 uses only step[0].
- Pattern:
  - Mode 1: step.
  - Mode 2: all bits = step[0].
  - Mode 3: all ones.
  - Mode 0: all zeros.
- Breathe FSM (mode 3), advances on tick only:
  - RAMP_UP: level +1. When level would reach brightness, set level = brightness and go to RAMP_DOWN.
  - RAMP_DOWN: level -1. When level would reach 0, set level = 0 and go to RAMP_UP.
  - If brightness drops below level (any cycle), clamp level = brightness next cycle and force RAMP_DOWN.
  - brightness = 0: level stays 0, state stays RAMP_UP, LEDs dark (invert suppressed).
- Mode change: mode_q registers mode. When mode != mode_q, the next clock clears prescaler, step and level, sets state = RAMP_UP, and suppresses tick for that cycle.
- Enable low: same clear as a mode change, held every cycle; led = 0 and tick = 0 after one clock.
- LED output, registered with 1-cycle latency:
  - led <= (enable and mode != 0 and pwm_on) ? (pattern ^ invert) : 0.
  - Mode 0 with pwm_on still gives 0; invert never lights a dark LED outside the on phase.
- Simultaneous events:
  - A tick coinciding with a mode change is dropped.
  - A tick coinciding with a brightness clamp: the clamp wins and the decrement applies on the following tick.
- Widths: all counters are unsigned; no saturation except the breathe clamps above.

Test Plan:
- Reset check (TICK_CYCLES=4, PWM_WIDTH=2, NUM_LEDS=4): assert rst_a_n low mid-run -> led = 0 and tick = 0 immediately (asynchronously); after release, the first tick arrives 5 clocks later.
- Binary count: mode=1, brightness=3, invert=0 -> led steps 0,1,2,...,15,0 on successive ticks, tick every 4 clocks; led updates 1 clock after tick.
- PWM duty: mode=2, step[0]=1, brightness=1 -> led = 4'hF for 1 of every 4 clocks and 0 for 3; brightness=0 -> led always 0.
- Invert: mode=1, step=0, invert=4'b1010, brightness=3 -> led = 4'b1010; with brightness=0 -> led = 0.
- Breathe: mode=3, brightness=2 -> level 0,1,2,1,0,1,... per tick. Drop brightness to 1 while level = 2 -> level = 1 next clock, then 0 on the next tick.
- Mode change / enable: switch mode 1->2 with step = 5 -> step cleared, no tick that cycle, next tick 4 clocks later. Enable low for 3 clocks -> led = 0 from the next clock; step = 0 on resume.
